// File: rtl/phy_tx_sequencer.sv
// PHY transmit sequencer: frames packets as STP / DATA / END (or EDB on
// abort) and inserts 4-cycle SKP ordered sets at a fixed interval, never
// inside a packet. All PHY-facing buses are driven from registers.
module phy_tx_sequencer #(
  parameter int SKP_INTERVAL = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PKT_VALID,
  input  logic [3:0] PKT_LEN,
  input  logic [7:0] PKT_DATA,
  input  logic       PKT_ABORT,
  output logic       PKT_ACK,
  output logic       PKT_RD,
  output logic       PKT_DONE,
  output logic       PKT_ERR,
  output logic [7:0] D,
  output logic [7:0] START_END,
  output logic [7:0] ORDERED_SET,
  output logic [7:0] LOG_COM,
  output logic [1:0] CONTROL,
  output logic       BUSY
);

  localparam logic [15:0] SKP_MAX = 16'(SKP_INTERVAL - 1);
  localparam logic [7:0]  SYM_STP = 8'hFB;
  localparam logic [7:0]  SYM_END = 8'hFD;
  localparam logic [7:0]  SYM_EDB = 8'hFE;
  localparam logic [7:0]  SYM_COM = 8'hBC;
  localparam logic [7:0]  SYM_SKP = 8'h1C;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STP  = 3'd1,
    ST_DATA = 3'd2,
    ST_END  = 3'd3,
    ST_SKP  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  len_r, len_s;
  logic [3:0]  rem_r, rem_s;
  logic [1:0]  skp_idx_r, skp_idx_s;
  logic [15:0] skp_cnt_r, skp_cnt_s;
  logic        skp_pending_s;
  logic        decide_s;
  logic        edb_s;

  logic        ack_r, ack_s;
  logic        rd_r, rd_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        busy_r, busy_s;
  logic [1:0]  ctrl_r, ctrl_s;
  logic [7:0]  d_r, d_s;
  logic [7:0]  se_r, se_s;
  logic [7:0]  os_r, os_s;

  assign skp_pending_s = (skp_cnt_r == SKP_MAX);

  // Next-state selection: IDLE, END and the last SKP cycle are decision points.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    rem_s     = rem_r;
    skp_idx_s = skp_idx_r;
    edb_s     = 1'b0;
    err_s     = 1'b0;
    decide_s  = (state_r == ST_IDLE) || (state_r == ST_END) ||
                ((state_r == ST_SKP) && (skp_idx_r == 2'd3));
    if (decide_s) begin
      if (skp_pending_s) begin
        state_s   = ST_SKP;
        skp_idx_s = 2'd0;
      end else if (PKT_VALID && (PKT_LEN != 4'd0)) begin
        state_s = ST_STP;
        len_s   = PKT_LEN;
      end else if (PKT_VALID) begin
        state_s = ST_IDLE;
        err_s   = 1'b1;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_STP: begin
          state_s = ST_DATA;
          rem_s   = len_r - 4'd1;
        end
        ST_DATA: begin
          if (PKT_ABORT) begin
            state_s = ST_END;
            edb_s   = 1'b1;
          end else if (rem_r == 4'd0) begin
            state_s = ST_END;
          end else begin
            rem_s = rem_r - 4'd1;
          end
        end
        ST_SKP:  skp_idx_s = skp_idx_r + 2'd1;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Skip counter: held at zero for the whole SKP so the period is interval + 4.
  always_comb begin
    if ((state_s == ST_SKP) || (state_r == ST_SKP)) begin
      skp_cnt_s = 16'd0;
    end else if (skp_cnt_r != SKP_MAX) begin
      skp_cnt_s = skp_cnt_r + 16'd1;
    end else begin
      skp_cnt_s = skp_cnt_r;
    end
  end

  // Output values for the state being entered, registered below.
  always_comb begin
    ack_s  = 1'b0;
    rd_s   = 1'b0;
    done_s = 1'b0;
    ctrl_s = 2'b11;
    d_s    = 8'h00;
    se_s   = 8'h00;
    os_s   = 8'h00;
    busy_s = (state_s != ST_IDLE);
    case (state_s)
      ST_STP: begin
        ctrl_s = 2'b01;
        se_s   = SYM_STP;
        ack_s  = 1'b1;
        rd_s   = 1'b1;
      end
      ST_DATA: begin
        ctrl_s = 2'b00;
        d_s    = PKT_DATA;
        rd_s   = (rem_s != 4'd0);
      end
      ST_END: begin
        ctrl_s = 2'b01;
        se_s   = edb_s ? SYM_EDB : SYM_END;
        done_s = 1'b1;
      end
      ST_SKP: begin
        ctrl_s = 2'b10;
        os_s   = (skp_idx_s == 2'd0) ? SYM_COM : SYM_SKP;
      end
      default: ctrl_s = 2'b11;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      len_r     <= 4'd0;
      rem_r     <= 4'd0;
      skp_idx_r <= 2'd0;
      skp_cnt_r <= 16'd0;
      ack_r     <= 1'b0;
      rd_r      <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      ctrl_r    <= 2'b11;
      d_r       <= 8'h00;
      se_r      <= 8'h00;
      os_r      <= 8'h00;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      rem_r     <= rem_s;
      skp_idx_r <= skp_idx_s;
      skp_cnt_r <= skp_cnt_s;
      ack_r     <= ack_s;
      rd_r      <= rd_s;
      done_r    <= done_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      ctrl_r    <= ctrl_s;
      d_r       <= d_s;
      se_r      <= se_s;
      os_r      <= os_s;
    end
  end

  // An abort withdraws the read in its own cycle, so only bytes that will
  // still reach D are ever consumed from the requester.
  assign PKT_RD      = rd_r & ~(PKT_ABORT & (state_r == ST_DATA));
  assign PKT_ACK     = ack_r;
  assign PKT_DONE    = done_r;
  assign PKT_ERR     = err_r;
  assign BUSY        = busy_r;
  assign CONTROL     = ctrl_r;
  assign D           = d_r;
  assign START_END   = se_r;
  assign ORDERED_SET = os_r;
  assign LOG_COM     = 8'h00;

endmodule

// File: tb/tb_phy_tx_sequencer.sv
// Directed bench for phy_tx_sequencer: expected PHY symbols are queued as
// stimulus is applied and popped by a negedge monitor as the DUT emits them.
module tb_phy_tx_sequencer;

  logic       CLK;
  logic       RESET;
  logic       PKT_VALID;
  logic [3:0] PKT_LEN;
  logic [7:0] PKT_DATA;
  logic       PKT_ABORT;
  logic       PKT_ACK, PKT_RD, PKT_DONE, PKT_ERR, BUSY;
  logic [7:0] D, START_END, ORDERED_SET, LOG_COM;
  logic [1:0] CONTROL;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_total = 0;
  int ack_total = 0;
  int done_total = 0;
  int err_total = 0;
  int pops = 0;
  int pops_base = 0;
  int idle_gap = 0;
  int exp_rd = 0;
  int b_ack, b_rd, b_done, b_err, b_gap;
  logic [9:0] exp_q[$];
  int skp_starts[$];

  phy_tx_sequencer #(.SKP_INTERVAL(32)) dut (
    .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .PKT_LEN(PKT_LEN),
    .PKT_DATA(PKT_DATA), .PKT_ABORT(PKT_ABORT), .PKT_ACK(PKT_ACK),
    .PKT_RD(PKT_RD), .PKT_DONE(PKT_DONE), .PKT_ERR(PKT_ERR), .D(D),
    .START_END(START_END), .ORDERED_SET(ORDERED_SET), .LOG_COM(LOG_COM),
    .CONTROL(CONTROL), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int n);
    logic [7:0] b;
    b = 8'hA1 + n[7:0];
    return b;
  endfunction

  task automatic push_sym(input logic [1:0] c, input logic [7:0] b);
    exp_q.push_back({c, b});
  endtask

  task automatic push_skp();
    push_sym(2'b10, 8'hBC);
    push_sym(2'b10, 8'h1C);
    push_sym(2'b10, 8'h1C);
    push_sym(2'b10, 8'h1C);
  endtask

  // Payload source: byte n of the overall stream after n reads consumed.
  always @(posedge CLK) begin
    #1;
    PKT_DATA = 8'hA1 + rd_total[7:0];
  end

  // Monitor: reset values, bus isolation, pulse counts and symbol scoreboard.
  always @(negedge CLK) begin
    logic [7:0] sel;
    logic [7:0] unsel;
    logic [9:0] e;
    if (RESET) begin
      cyc = 0;
      chk("reset_ctrl", {30'd0, CONTROL}, 32'd3);
      chk("reset_bus", {D, START_END, ORDERED_SET, LOG_COM}, 32'd0);
      chk("reset_flags", {27'd0, PKT_ACK, PKT_RD, PKT_DONE, PKT_ERR, BUSY}, 32'd0);
    end else begin
      unsel = ((CONTROL != 2'b00) ? D : 8'h00) | ((CONTROL != 2'b01) ? START_END : 8'h00) |
              ((CONTROL != 2'b10) ? ORDERED_SET : 8'h00) | LOG_COM;
      chk("unsel_bus_zero", {24'd0, unsel}, 32'd0);
      chk("busy_vs_ctrl", {31'd0, BUSY}, {31'd0, (CONTROL != 2'b11)});
      if (PKT_ACK)  ack_total++;
      if (PKT_RD)   rd_total++;
      if (PKT_DONE) done_total++;
      if (PKT_ERR)  err_total++;
      if (CONTROL != 2'b11) begin
        case (CONTROL)
          2'b00:   sel = D;
          2'b01:   sel = START_END;
          default: sel = ORDERED_SET;
        endcase
        if (CONTROL == 2'b10 && ORDERED_SET == 8'hBC) skp_starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_symbol", {22'd0, CONTROL, sel}, 32'h3FF);
        end else begin
          e = exp_q.pop_front();
          pops++;
          chk("symbol", {22'd0, CONTROL, sel}, {22'd0, e});
        end
      end else if (exp_q.size() != 0 && pops > pops_base) begin
        idle_gap++;
      end
      cyc++;
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    PKT_VALID = 1'b0;
    PKT_ABORT = 1'b0;
    PKT_LEN = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_async_ctrl", {30'd0, CONTROL}, 32'd3);
    RESET = 1'b0;
    skp_starts.delete();
    b_ack = ack_total; b_rd = rd_total; b_done = done_total; b_err = err_total;
    b_gap = idle_gap; pops_base = pops;
  endtask

  task automatic wait_ack(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!PKT_ACK && k < 20);
    chk(tag, {31'd0, PKT_ACK}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    PKT_VALID = 1'b0;
    PKT_ABORT = 1'b0;
    PKT_LEN = 4'd0;

    // Idle: SKP at cycle 32 after reset, then every 36 cycles.
    do_reset();
    push_skp(); push_skp(); push_skp();
    repeat (110) @(negedge CLK);
    drain("idle_skp_drain");
    chk("idle_skp_count", skp_starts.size(), 32'd3);
    if (skp_starts.size() == 3) begin
      chk("idle_skp_first", skp_starts[0], 32'd32);
      chk("idle_skp_second", skp_starts[1], 32'd68);
      chk("idle_skp_third", skp_starts[2], 32'd104);
    end

    // 3-byte packet; abort during STP is ignored; LEN change after ACK ignored.
    do_reset();
    push_sym(2'b01, 8'hFB);
    for (int i = 0; i < 3; i++) push_sym(2'b00, pay(exp_rd + i));
    push_sym(2'b01, 8'hFD);
    PKT_VALID = 1'b1; PKT_LEN = 4'd3;
    @(posedge CLK); #1;
    PKT_ABORT = 1'b1;
    wait_ack("pkt3_ack");
    @(posedge CLK); #1;
    PKT_VALID = 1'b0; PKT_ABORT = 1'b0; PKT_LEN = 4'd9;
    drain("pkt3_drain");
    exp_rd += 3;
    chk("pkt3_ack_cnt", ack_total - b_ack, 32'd1);
    chk("pkt3_rd_cnt", rd_total - b_rd, 32'd3);
    chk("pkt3_done_cnt", done_total - b_done, 32'd1);

    // 5-byte packet aborted in its second data cycle -> EDB.
    do_reset();
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd));
    push_sym(2'b00, pay(exp_rd + 1));
    push_sym(2'b01, 8'hFE);
    PKT_VALID = 1'b1; PKT_LEN = 4'd5;
    wait_ack("abort_ack");
    @(posedge CLK); #1;
    PKT_VALID = 1'b0;
    @(posedge CLK); #1;
    PKT_ABORT = 1'b1;
    @(posedge CLK); #1;
    PKT_ABORT = 1'b0;
    drain("abort_drain");
    exp_rd += 2;
    chk("abort_rd_cnt", rd_total - b_rd, 32'd2);
    chk("abort_done_cnt", done_total - b_done, 32'd1);

    // Two back-to-back 2-byte packets with no idle gap.
    do_reset();
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd)); push_sym(2'b00, pay(exp_rd + 1));
    push_sym(2'b01, 8'hFD);
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd + 2)); push_sym(2'b00, pay(exp_rd + 3));
    push_sym(2'b01, 8'hFD);
    PKT_VALID = 1'b1; PKT_LEN = 4'd2;
    wait_ack("b2b_ack1");
    wait_ack("b2b_ack2");
    @(posedge CLK); #1;
    PKT_VALID = 1'b0;
    drain("b2b_drain");
    exp_rd += 4;
    chk("b2b_gap", idle_gap - b_gap, 32'd0);
    chk("b2b_ack_cnt", ack_total - b_ack, 32'd2);
    chk("b2b_done_cnt", done_total - b_done, 32'd2);

    // SKP becoming pending mid-packet is deferred until after FD.
    do_reset();
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd)); push_sym(2'b00, pay(exp_rd + 1));
    push_sym(2'b01, 8'hFD);
    push_skp();
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd + 2)); push_sym(2'b00, pay(exp_rd + 3));
    push_sym(2'b01, 8'hFD);
    repeat (28) @(posedge CLK);
    #1;
    PKT_VALID = 1'b1; PKT_LEN = 4'd2;
    wait_ack("skpmid_ack1");
    wait_ack("skpmid_ack2");
    @(posedge CLK); #1;
    PKT_VALID = 1'b0;
    drain("skpmid_drain");
    exp_rd += 4;
    chk("skpmid_gap", idle_gap - b_gap, 32'd0);
    chk("skpmid_skp_count", skp_starts.size(), 32'd1);
    if (skp_starts.size() == 1) chk("skpmid_skp_cycle", skp_starts[0], 32'd33);

    // Zero-length request: PKT_ERR only, no symbols.
    do_reset();
    PKT_VALID = 1'b1; PKT_LEN = 4'd0;
    @(posedge CLK); #1;
    PKT_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    chk("zlen_err_cnt", err_total - b_err, 32'd1);
    chk("zlen_ack_cnt", ack_total - b_ack, 32'd0);

    // Reset during DATA abandons the packet; first SKP 32 cycles later.
    do_reset();
    push_sym(2'b01, 8'hFB);
    push_sym(2'b00, pay(exp_rd));
    PKT_VALID = 1'b1; PKT_LEN = 4'd5;
    wait_ack("rstmid_ack");
    @(posedge CLK); #1;
    PKT_VALID = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("rstmid_ctrl", {30'd0, CONTROL}, 32'd3);
    chk("rstmid_bus", {D, START_END, ORDERED_SET, LOG_COM}, 32'd0);
    chk("rstmid_busy", {31'd0, BUSY}, 32'd0);
    exp_rd += 2;
    chk("rstmid_rd_cnt", rd_total - b_rd, 32'd2);
    b_done = done_total;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    skp_starts.delete();
    push_skp();
    repeat (40) @(negedge CLK);
    drain("rstmid_drain");
    chk("rstmid_done_cnt", done_total - b_done, 32'd0);
    chk("rstmid_skp_count", skp_starts.size(), 32'd1);
    if (skp_starts.size() == 1) chk("rstmid_skp_cycle", skp_starts[0], 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_tx_sequencer.md
PHY_TX_SEQUENCER -- requirements
Module: phy_tx_sequencer

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 32, meaning cycles between SKP ordered-set insertions (range 8..65535).
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port PKT_VALID  input  1  packet request pending.
REQ-005 SHALL have port PKT_LEN  input  4  payload byte count (1..15); sampled with PKT_VALID.
REQ-006 SHALL have port PKT_DATA  input  8  payload byte; consumed in PKT_RD cycles.
REQ-007 SHALL have port PKT_ABORT  input  1  abort current packet (nullify).
REQ-008 SHALL have port PKT_ACK  output  1  one-cycle pulse: request accepted, PKT_LEN latched.
REQ-009 SHALL have port PKT_RD  output  1  PKT_DATA consumed this cycle.
REQ-010 SHALL have port PKT_DONE  output  1  one-cycle pulse in END cycle.
REQ-011 SHALL have port PKT_ERR  output  1  one-cycle pulse: zero-length request rejected.
REQ-012 SHALL have ports D, START_END, ORDERED_SET, LOG_COM  output  8 each  PHY source buses.
REQ-013 SHALL have port CONTROL  output  2  PHY source select: 00 D, 01 START_END, 10 ORDERED_SET, 11 LOG_COM.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, STP, DATA, END, SKP; all outputs registered.
REQ-016 IDLE SHALL drive CONTROL=11, LOG_COM=0x00; LOG_COM is 0x00 in every state.
REQ-017 Any source bus not selected by CONTROL SHALL be 0x00.
REQ-018 Free-running 16-bit skip counter SHALL increment each cycle, saturate at SKP_INTERVAL-1, set skp_pending there, and clear to 0 on SKP entry.
REQ-019 From IDLE or END: skp_pending -> SKP (priority over packets); else PKT_VALID with PKT_LEN!=0 -> STP; else PKT_VALID with PKT_LEN==0 -> PKT_ERR pulse next cycle, stay/go IDLE; else IDLE.
REQ-020 SKP SHALL last exactly 4 cycles with CONTROL=10, ORDERED_SET = 0xBC, 0x1C, 0x1C, 0x1C, then re-evaluate per REQ-019.
REQ-021 SKP SHALL never be inserted inside a packet; pending SKP waits for END.
REQ-022 STP: one cycle, CONTROL=01, START_END=0xFB, PKT_ACK=1, PKT_RD=1, PKT_LEN latched.
REQ-023 DATA: CONTROL=00, lasting exactly latched-length cycles; PKT_RD=1 in every DATA cycle except the last.
REQ-024 Byte on PKT_DATA in a PKT_RD cycle SHALL appear on D in the following cycle; total PKT_RD pulses = latched length.
REQ-025 END: one cycle, CONTROL=01, START_END=0xFD, PKT_DONE=1.
REQ-026 PKT_ABORT high at a DATA-cycle edge SHALL force END next cycle with START_END=0xFE (EDB), PKT_RD=0 from then on; remaining bytes dropped; PKT_DONE pulses.
REQ-027 PKT_ABORT outside DATA SHALL be ignored.
REQ-028 Back-to-back packets: END -> STP directly when PKT_VALID high and no skp_pending (no idle gap).
REQ-029 Requester SHALL hold PKT_VALID/PKT_LEN stable until PKT_ACK; PKT_VALID sampled in END is a new request.
REQ-030 PKT_LEN changes after PKT_ACK SHALL not affect the current packet.

Reset
REQ-031 RESET high SHALL immediately force IDLE, skip counter 0, skp_pending 0, latched length 0.
REQ-032 During/after reset: CONTROL=11, all buses 0x00, PKT_ACK/PKT_RD/PKT_DONE/PKT_ERR/BUSY 0.
REQ-033 Reset mid-packet or mid-SKP SHALL abandon it without END/EDB; first post-reset SKP after SKP_INTERVAL cycles.

Verification
REQ-034 Reset, no requests, SKP_INTERVAL=32 -> CONTROL=11 idle; at counter saturation 4 cycles CONTROL=10 with BC,1C,1C,1C; repeats every 36 cycles.
REQ-035 PKT_LEN=3, data A1,A2,A3 -> FB, A1,A2,A3 (CONTROL=00), FD; PKT_ACK once, 3 PKT_RD, PKT_DONE once.
REQ-036 PKT_ABORT during 2nd data cycle of 5-byte packet -> bytes 1,2 then FE; PKT_DONE pulses, 2 PKT_RD total.
REQ-037 Two queued 2-byte packets -> FB,d,d,FD,FB,d,d,FD contiguous; skp_pending arising mid-packet -> SKP inserted after FD before second FB.
REQ-038 PKT_LEN=0 request -> PKT_ERR pulse, no STP, CONTROL stays 11; RESET asserted during DATA -> CONTROL=11 immediately, no FD/FE.
